apb_bus_arbiter: RTL and testbench

- Two-requester APB master that shares the single APB port of the AES/UART bridge subsystem.
- Typical requesters: a configuration sequencer on port 0 and a data-streaming engine on port 1.
- Accepts latched read/write requests, grants them round-robin and runs the APB SETUP/ACCESS phases with wait-state and timeout handling.
- Returns read data and error status to the granted requester.

---
 rtl/apb_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// Two-requester APB master: round-robin grant, one outstanding transfer,
// wait-state tracking with optional timeout abort.
module apb_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_write,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY,
  input  logic            PSLVERR
);

  // state  | meaning
  // IDLE   | no transfer; grant and accept a request
  // SETUP  | PSEL high, PENABLE low, one cycle
  // ACCESS | PSEL/PENABLE high until PREADY or timeout
  // RESP   | one-cycle rsp_valid to the granted requester
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam bit             TO_EN     = (TIMEOUT > 0);
  localparam int             WCW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = TO_EN ? WCW'(TIMEOUT - 1) : '0;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_q, grant_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           psel_q, psel_d;
  logic           penable_q, penable_d;
  logic           pwrite_q, pwrite_d;
  logic [AW-1:0]  paddr_q, paddr_d;
  logic [DW-1:0]  pwdata_q, pwdata_d;
  logic [1:0]     rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;

  logic           any_req;
  logic           gsel;
  logic           finish;

  always_comb begin
    any_req = |req_valid;
    gsel    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;
    finish       = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready    = gsel ? 2'b10 : 2'b01;
          grant_d      = gsel;
          last_grant_d = gsel;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = req_write[gsel];
          paddr_d      = gsel ? req_addr[AW +: AW] : req_addr[0 +: AW];
          if (req_write[gsel])
            pwdata_d = gsel ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
          else
            pwdata_d = '0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          finish      = 1'b1;
        end else if (TO_EN && (wait_cnt_q == WAIT_LAST)) begin
          // slave never answered: abort with an error and no data
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          finish      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      pwrite_d    = 1'b0;
      paddr_d     = '0;
      pwdata_d    = '0;
      wait_cnt_d  = '0;
      rsp_valid_d = grant_q ? 2'b10 : 2'b01;
      state_d     = RESP;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wait_cnt_q   <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wait_cnt_q   <= wait_cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: directed scenarios plus random traffic checked
// against a transaction-timeline model; a second instance has no timeout.
module tb_apb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  logic [1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0] PADDR;
  logic rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  logic [1:0] nt_req_ready, nt_rsp_valid;
  logic [DW-1:0] nt_rsp_rdata, nt_pwdata;
  logic [AW-1:0] nt_paddr;
  logic nt_rsp_err, nt_psel, nt_penable, nt_pwrite;

  apb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  apb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(0)) u_nt (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_ready(nt_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(nt_rsp_valid), .rsp_rdata(nt_rsp_rdata), .rsp_err(nt_rsp_err),
    .PSEL(nt_psel), .PENABLE(nt_penable), .PWRITE(nt_pwrite), .PADDR(nt_paddr),
    .PWDATA(nt_pwdata), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;

  // stimulus
  bit rv[2], rw[2];
  logic [31:0] ra[2], rd[2];
  logic rst, pready, pslverr;
  logic [31:0] prdata;

  // reference model: where the current transaction is on its timeline
  bit m_busy, m_access, m_resp, m_g, m_last, m_write, m_err, hs, hs_g;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int m_low;

  // per-cycle snapshot of DUT outputs
  logic [1:0] s_ready, s_rvalid, s_nt_pp, s_nt_rv;
  logic [31:0] s_rdata, s_pwdata;
  logic s_err, s_psel, s_pen;

  int cyc, n_chk, n_err, t_rsp;
  bit nt_ok;
  bit q_g[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit pick();
    if (rv[0] && rv[1]) return ~m_last;
    return rv[1];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_access = 0; m_resp = 0; m_last = 1; m_rdata = 0; m_err = 0; m_low = 0;
  endtask

  task automatic do_reset();
    rv = '{0, 0};
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    PREADY = 0; PRDATA = 0; PSLVERR = 0; PRESET = 1;
    @(posedge PCLK); @(posedge PCLK); @(negedge PCLK);
    PRESET = 0; rst = 0;
    model_reset();
  endtask

  task automatic step();
    logic [1:0] e_ready, e_rv;
    logic e_psel, e_pen, e_pw;
    logic [31:0] e_addr, e_wd;
    req_valid = {rv[1], rv[0]};
    req_write = {rw[1], rw[0]};
    req_addr  = {ra[1], ra[0]};
    req_wdata = {rd[1], rd[0]};
    PRESET = rst; PREADY = pready; PRDATA = prdata; PSLVERR = pslverr;
    #1;
    s_ready = req_ready; s_rvalid = rsp_valid; s_rdata = rsp_rdata; s_err = rsp_err;
    s_psel = PSEL; s_pen = PENABLE; s_pwdata = PWDATA;
    s_nt_pp = {nt_psel, nt_penable}; s_nt_rv = nt_rsp_valid;

    e_ready = 0; e_rv = 0; e_psel = 0; e_pen = 0; e_pw = 0; e_addr = 0; e_wd = 0;
    if (m_resp) e_rv = m_g ? 2'b10 : 2'b01;
    else if (m_busy) begin
      e_psel = 1; e_pen = m_access; e_addr = m_addr; e_pw = m_write;
      e_wd = m_write ? m_wdata : 32'h0;
    end else if (rv[0] || rv[1]) e_ready = pick() ? 2'b10 : 2'b01;
    chk("req_ready", s_ready, e_ready);
    chk("rsp_valid", s_rvalid, e_rv);
    chk("rsp_rdata", s_rdata, m_rdata);
    chk("rsp_err", s_err, m_err);
    chk("psel", s_psel, e_psel);
    chk("penable", s_pen, e_pen);
    chk("pwrite", PWRITE, e_pw);
    chk("paddr", PADDR, e_addr);
    chk("pwdata", s_pwdata, e_wd);

    hs = 0;
    if (rst) model_reset();
    else if (m_resp) m_resp = 0;
    else if (!m_busy) begin
      if (rv[0] || rv[1]) begin
        m_g = pick(); hs = 1; m_last = m_g;
        m_write = rw[m_g]; m_addr = ra[m_g]; m_wdata = rd[m_g];
        m_busy = 1; m_access = 0;
      end
    end else if (!m_access) begin
      m_access = 1; m_low = 0;
    end else if (pready) begin
      m_rdata = m_write ? 32'h0 : prdata; m_err = pslverr; m_busy = 0; m_resp = 1;
    end else begin
      m_low++;
      if (TO > 0 && m_low == TO) begin
        m_rdata = 0; m_err = 1; m_busy = 0; m_resp = 1;
      end
    end
    hs_g = m_g;
    @(posedge PCLK); @(negedge PCLK);
    cyc++;
    if (hs) rv[hs_g] = 0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    rw = '{0, 0}; ra = '{0, 0}; rd = '{0, 0};
    rst = 0; pready = 0; pslverr = 0; prdata = 0;
    m_g = 0; m_write = 0; m_addr = 0; m_wdata = 0; hs = 0; hs_g = 0;
    do_reset();

    step();
    chk("reset_apb", {s_psel, s_pen, s_rvalid}, 4'b0000);
    chk("reset_rdata", s_rdata, 0);

    // zero-wait write from requester 0
    rv[0] = 1; rw[0] = 1; ra[0] = 32'h10; rd[0] = 32'hA5A5_0001; pready = 1;
    step(); chk("wr_hs", s_ready, 2'b01);
    step(); chk("wr_setup", {s_psel, s_pen}, 2'b10); chk("wr_pwdata", s_pwdata, 32'hA5A5_0001);
    step(); chk("wr_access", {s_psel, s_pen}, 2'b11); chk("wr_pwdata2", s_pwdata, 32'hA5A5_0001);
    step(); chk("wr_resp", s_rvalid, 2'b01); chk("wr_err", s_err, 0);
    step();

    // read from requester 1 with three wait states; PSLVERR pulse while PREADY low
    rv[1] = 1; rw[1] = 0; ra[1] = 32'h24; rd[1] = 32'h5555_5555; t_rsp = -1;
    for (int i = 0; i < 7; i++) begin
      pready  = (i == 1) || (i == 5);
      pslverr = (i == 3);
      prdata  = (i == 5) ? 32'hDEAD_BEEF : 32'h0BAD_0000 + i;
      step();
      if (s_rvalid != 0 && t_rsp < 0) t_rsp = i;
    end
    chk("rd_latency", t_rsp, 6);
    chk("rd_rvalid", s_rvalid, 2'b10);
    chk("rd_rdata", s_rdata, 32'hDEAD_BEEF);
    chk("rd_err", s_err, 0);
    pslverr = 0;

    // slave error on a read
    rv[0] = 1; rw[0] = 0; ra[0] = 32'h30; pready = 1; pslverr = 1; prdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) step();
    chk("err_rvalid", s_rvalid, 2'b01);
    chk("err_flag", s_err, 1);
    chk("err_rdata", s_rdata, 32'h1234_5678);
    pslverr = 0;

    // round robin with both requesters continuously valid
    do_reset();
    pready = 1;
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < 2; n++)
        if (!rv[n]) begin
          rv[n] = 1; rw[n] = $urandom_range(0, 1); ra[n] = $urandom; rd[n] = $urandom;
        end
      prdata = $urandom;
      step();
      if (s_ready != 0) q_g.push_back(s_ready[1]);
    end
    chk("rr_count", q_g.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", (i < q_g.size()) ? 64'(q_g[i]) : 64'd2, i % 2);
    rv = '{0, 0};
    step();

    // reset during an ACCESS wait state
    rv[0] = 1; rw[0] = 0; ra[0] = 32'h40; pready = 0;
    for (int i = 0; i < 4; i++) step();
    rst = 1; step(); rst = 0;
    step(); chk("mid_rst_apb", {s_psel, s_pen}, 2'b00); chk("mid_rst_rv", s_rvalid, 2'b00);
    step(); chk("mid_rst_rv2", s_rvalid, 2'b00);
    rv[0] = 1; rv[1] = 1; rw[0] = 1; rw[1] = 1; ra[0] = 32'h44; ra[1] = 32'h48; pready = 1;
    step(); chk("mid_rst_tie", s_ready, 2'b01);
    for (int i = 0; i < 8; i++) step();

    // timeout with PREADY held low; the TIMEOUT=0 instance keeps waiting
    do_reset();
    rv[1] = 1; rw[1] = 1; ra[1] = 32'h50; rd[1] = 32'hCAFE_0001; pready = 0; t_rsp = -1;
    for (int i = 0; i < 19; i++) begin
      step();
      if (s_rvalid != 0 && t_rsp < 0) t_rsp = i;
    end
    chk("to_latency", t_rsp, 18);
    chk("to_rvalid", s_rvalid, 2'b10);
    chk("to_err", s_err, 1);
    chk("to_rdata", s_rdata, 0);
    chk("to_psel", {s_psel, s_pen}, 2'b00);
    chk("nt_hold", s_nt_pp, 2'b11);
    nt_ok = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_nt_pp != 2'b11 || s_nt_rv != 2'b00) nt_ok = 0;
    end
    chk("nt_wait", nt_ok, 1);
    chk("nt_paddr", nt_paddr, 32'h50);
    chk("nt_pwdata", nt_pwdata, 32'hCAFE_0001);
    chk("nt_pwrite", nt_pwrite, 1);
    chk("nt_ready", nt_req_ready, 2'b00);
    pready = 1;
    step(); step();
    chk("nt_done", s_nt_rv, 2'b10);
    chk("nt_err", nt_rsp_err, 0);
    chk("nt_rdata", nt_rsp_rdata, 0);
    pready = 0;

    // random traffic
    do_reset();
    begin
      int lowrun;
      lowrun = 0;
      for (int c = 0; c < 3000; c++) begin
        for (int n = 0; n < 2; n++)
          if (!rv[n] && $urandom_range(0, 3) == 0) begin
            rv[n] = 1; rw[n] = $urandom_range(0, 1); ra[n] = $urandom; rd[n] = $urandom;
          end
        if (lowrun == 0 && $urandom_range(0, 199) == 0) lowrun = 20;
        if (lowrun > 0) begin
          pready = 0; lowrun--;
        end else pready = ($urandom_range(0, 9) < 6);
        pslverr = ($urandom_range(0, 3) == 0);
        prdata  = $urandom;
        rst     = m_busy && ($urandom_range(0, 299) == 0);
        step();
      end
      rst = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
